// File: rtl/frame_done_gen.sv
// frame_done_gen: counts pixels of a frame, then emits a fixed-width active-low frame_done pulse
// followed by a dead gap; frame_enable arms each frame and aborts one in progress when dropped.
module frame_done_gen #(
  parameter int H_PIX     = 320,
  parameter int V_LINES   = 240,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 8
) (
  input  logic           iclk,
  input  logic           irst,
  input  logic           frame_enable,
  input  logic           pix_valid,
  output logic           pix_ready,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_done,
  output logic [15:0]    frame_cnt,
  output logic           abort
);
  localparam int T_MAX = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
  localparam int T_W   = T_MAX > 1 ? $clog2(T_MAX) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, PULSE, GAP} state_t;
  state_t         state_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [15:0]    cnt_q;
  logic [T_W-1:0] tmr_q;
  logic           done_q, abort_q;
  logic           last_x, last_y;
  assign last_x     = x_q == X_W'(H_PIX - 1);
  assign last_y     = y_q == Y_W'(V_LINES - 1);
  assign pix_ready  = state_q == ACTIVE;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign abort      = abort_q;
  // Pulse and gap share one timer; it is cleared on every entry to PULSE or GAP.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b1;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_enable) state_q <= ACTIVE;
        ACTIVE:
          if (!frame_enable) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            abort_q <= 1'b1;
          end else if (pix_valid) begin
            x_q <= last_x ? '0 : x_q + 1'b1;
            if (last_x) y_q <= last_y ? '0 : y_q + 1'b1;
            if (last_x && last_y) begin
              state_q <= PULSE;
              done_q  <= 1'b0;
              cnt_q   <= cnt_q + 16'd1;
              tmr_q   <= '0;
            end
          end
        PULSE:
          if (tmr_q == T_W'(PULSE_LEN - 1)) begin
            state_q <= GAP;
            done_q  <= 1'b1;
            tmr_q   <= '0;
          end else tmr_q <= tmr_q + 1'b1;
        GAP:
          if (tmr_q == T_W'(GAP_LEN - 1)) state_q <= IDLE;
          else tmr_q <= tmr_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_done_gen.sv
// tb_frame_done_gen: scoreboard bench; expected pixel coordinates are queued per frame and
// popped on each observed accept, with pulse/gap timing and abort checks per scenario.
module tb_frame_done_gen;
  localparam int H = 4, V = 3, XW = 2, YW = 2, PL = 2, GL = 3;
  logic          iclk = 1'b0, irst = 1'b1, frame_enable = 1'b0, pix_valid = 1'b0;
  logic          pix_ready, frame_done, abort;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   frame_cnt;
  int checks = 0, failures = 0;
  typedef struct {int x; int y;} pix_t;
  pix_t sb[$];
  frame_done_gen #(.H_PIX(H), .V_LINES(V), .X_W(XW), .Y_W(YW), .PULSE_LEN(PL), .GAP_LEN(GL)) dut (
    .iclk(iclk), .irst(irst), .frame_enable(frame_enable), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .abort(abort)
  );
  always #5 iclk = ~iclk;
  task automatic step;
    @(posedge iclk);
    #1;
  endtask
  task automatic push_frame;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) sb.push_back('{x, y});
  endtask
  task automatic feed(input int n, input bit stall, output int cyc);
    int got = 0;
    pix_t e;
    cyc = 0;
    while (got < n && cyc < 200) begin
      pix_valid = stall ? (cyc % 2 == 0) : 1'b1;
      if (pix_valid && pix_ready) begin
        e = sb.pop_front();
        got++;
        checks++;
        if (pix_x !== XW'(e.x) || pix_y !== YW'(e.y)) begin
          failures++;
          $display("FAIL pix_xy: got (%0d,%0d) expected (%0d,%0d)", pix_x, pix_y, e.x, e.y);
        end
        checks++;
        if (frame_done !== 1'b1) begin
          failures++;
          $display("FAIL done_early: frame_done=%b before accept %0d, expected 1", frame_done, got);
        end
      end
      step;
      cyc++;
    end
    pix_valid = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL feed_timeout: got %0d accepts expected %0d", got, n);
    end
  endtask
  task automatic check_pulse_gap(input int exp_cnt);
    int n_low = 0, n_nr = 0;
    for (int i = 0; i < 30 && !pix_ready; i++) begin
      if (!frame_done) n_low++;
      n_nr++;
      step;
    end
    checks++;
    if (n_low != PL) begin
      failures++;
      $display("FAIL pulse_len: low for %0d cycles expected %0d", n_low, PL);
    end
    checks++;
    if (n_nr != PL + GL + 1) begin
      failures++;
      $display("FAIL rearm: ready low for %0d cycles expected %0d", n_nr, PL + GL + 1);
    end
    checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt);
    end
  endtask
  task automatic test_reset;
    frame_enable = 1'b1;
    step;
    step;
    checks++;
    if (frame_done !== 1'b1 || pix_ready !== 1'b0 || frame_cnt !== 16'd0 || abort !== 1'b0) begin
      failures++;
      $display("FAIL reset: done=%b ready=%b cnt=%0d abort=%b expected 1 0 0 0", frame_done, pix_ready, frame_cnt, abort);
    end
    irst = 1'b0;
    checks++;
    if (pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL arm_early: ready=%b expected 0", pix_ready);
    end
    step;
    checks++;
    if (pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL arm: ready=%b expected 1", pix_ready);
    end
  endtask
  task automatic test_full_frame;
    int c;
    push_frame;
    feed(H * V, 1'b0, c);
    checks++;
    if (c != H * V) begin
      failures++;
      $display("FAIL full_cycles: %0d expected %0d", c, H * V);
    end
    check_pulse_gap(1);
  endtask
  task automatic test_stalls;
    int c;
    push_frame;
    feed(H * V, 1'b1, c);
    checks++;
    if (c != 2 * H * V - 1) begin
      failures++;
      $display("FAIL stall_cycles: %0d expected %0d", c, 2 * H * V - 1);
    end
    check_pulse_gap(2);
  endtask
  task automatic test_abort;
    int c;
    push_frame;
    feed(5, 1'b0, c);
    frame_enable = 1'b0;
    pix_valid = 1'b1;
    step;
    pix_valid = 1'b0;
    sb.delete();
    checks++;
    if (abort !== 1'b1 || pix_x !== '0 || pix_y !== '0 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort: abort=%b x=%0d y=%0d ready=%b expected 1 0 0 0", abort, pix_x, pix_y, pix_ready);
    end
    checks++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL abort_keep: done=%b cnt=%0d expected 1 2", frame_done, frame_cnt);
    end
    step;
    checks++;
    if (abort !== 1'b0 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: abort=%b ready=%b expected 0 0", abort, pix_ready);
    end
    frame_enable = 1'b1;
    step;
    push_frame;
    feed(H * V, 1'b0, c);
    checks++;
    if (c != H * V) begin
      failures++;
      $display("FAIL abort_refeed: %0d cycles expected %0d", c, H * V);
    end
    check_pulse_gap(3);
  endtask
  task automatic test_ignore;
    int c, n_low = 0, n_rdy = 0;
    push_frame;
    feed(H * V, 1'b0, c);
    frame_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!frame_done) n_low++;
      if (pix_ready) n_rdy++;
      step;
    end
    checks++;
    if (n_low != PL || n_rdy != 0 || frame_cnt !== 16'd4) begin
      failures++;
      $display("FAIL ignore: low=%0d ready=%0d cnt=%0d expected %0d 0 4", n_low, n_rdy, frame_cnt, PL);
    end
    frame_enable = 1'b1;
    step;
    checks++;
    if (pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_rearm: ready=%b expected 1", pix_ready);
    end
  endtask
  task automatic test_async_reset;
    int c;
    push_frame;
    feed(H * V, 1'b0, c);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_pulse: done=%b expected 0", frame_done);
    end
    #2 irst = 1'b1;
    #1;
    checks++;
    if (frame_done !== 1'b1 || pix_x !== '0 || pix_y !== '0 || frame_cnt !== 16'd0 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: done=%b x=%0d y=%0d cnt=%0d ready=%b expected 1 0 0 0 0", frame_done, pix_x, pix_y, frame_cnt, pix_ready);
    end
    step;
    irst = 1'b0;
  endtask
  initial begin
    test_reset;
    test_full_frame;
    test_stalls;
    test_abort;
    test_ignore;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_done_gen.md
# frame_done_gen

Transmitter side of the `frame_done` / `frame_enable` frame-sync handshake between the pixel path and the LCD path. Counts pixels accepted from the upstream pixel stream, then emits one active-low `frame_done` pulse of fixed width after the last pixel of a frame. The frame-done delay block consumes that pulse and returns `frame_enable`, which re-arms this block for the next frame. Sits between the OV7670 capture/buffer read stage and the ILI9341 writer.

## Interface
Parameters:
- `H_PIX`, default 320: pixels per line.
- `V_LINES`, default 240: lines per frame.
- `X_W`, default 9: width of the column counter; must satisfy 2^X_W ≥ H_PIX.
- `Y_W`, default 8: width of the line counter; must satisfy 2^Y_W ≥ V_LINES.
- `PULSE_LEN`, default 4: `frame_done` low time in cycles, ≥1.
- `GAP_LEN`, default 8: dead cycles after the pulse before re-arming, ≥1.

Ports:
- `iclk` in 1: the single clock.
- `irst` in 1: reset, asynchronous and active-high.
- `frame_enable` in 1: arm/permit from the frame-done delay block.
- `pix_valid` in 1: upstream pixel available.
- `pix_ready` out 1: block accepts pixels; equals (state == ACTIVE).
- `pix_x` out X_W: column of the next pixel to be accepted.
- `pix_y` out Y_W: line of the next pixel to be accepted.
- `frame_done` out 1: active-low end-of-frame pulse; idle high.
- `frame_cnt` out 16: completed frames, wraps at 65535 → 0.
- `abort` out 1: one-cycle high pulse when a frame is aborted.

## Operation
- Accept = `pix_valid` & `pix_ready`, sampled on the rising edge of `iclk`.
- The state machine is IDLE, ACTIVE, PULSE, GAP.
- **IDLE**
  - `frame_done`=1, counters held at 0.
  - Go to ACTIVE on the first cycle with `frame_enable`=1.
- **ACTIVE**
  - On each accept, `pix_x` increments.
  - At `pix_x`=H_PIX-1, `pix_x`→0 and `pix_y` increments.
  - An accept at (H_PIX-1, V_LINES-1) is the last pixel. On that edge:
    - state→PULSE,
    - `frame_done`→0,
    - `pix_x`,`pix_y`→0,
    - `frame_cnt`+1.
  - If `frame_enable`=0 in ACTIVE, the frame is aborted:
    - state→IDLE, counters→0, `abort`=1 for one cycle,
    - `frame_done` stays 1 and `frame_cnt` is unchanged.
  - Abort has priority over any accept on the same edge; that pixel is not counted.
- **PULSE**
  - `frame_done` is held 0 for exactly PULSE_LEN cycles, then goes to 1 and state→GAP.
  - `frame_enable` is ignored.
- **GAP**
  - `frame_done`=1 and no accepts, for GAP_LEN cycles, then state→IDLE.
  - `frame_enable` is ignored.
- From IDLE, `frame_enable` already high re-arms immediately (one cycle in IDLE).
- `frame_done` is driven directly from a register with no combinational path, so it is glitch-free.
- Counter arithmetic is unsigned. `pix_x`/`pix_y` never exceed H_PIX-1/V_LINES-1. `frame_cnt` wraps modulo 2^16.
- Reset values, applied asynchronously while `irst`=1:
  - state IDLE,
  - `frame_done`=1, `pix_ready`=0, `abort`=0,
  - `pix_x`=0, `pix_y`=0, `frame_cnt`=0.
- Reset mid-PULSE returns `frame_done` to 1 immediately, with no truncated pulse held.

## Timing
- `pix_ready` rises on the first edge after `frame_enable` is seen in IDLE, i.e. 1 cycle of arm latency.
- Last-pixel accept edge → `frame_done` low on that same edge.
  - It stays low for PULSE_LEN cycles, then is high for GAP_LEN cycles.
  - `pix_ready` returns no earlier than PULSE_LEN+GAP_LEN+1 cycles after the last accept.
- With `pix_valid` held high, a frame takes H_PIX·V_LINES accept cycles.
  - Frame-to-frame period is H_PIX·V_LINES + PULSE_LEN + GAP_LEN + 1 cycles when `frame_enable` stays high.
- `abort` is asserted on the edge that leaves ACTIVE and is cleared on the next edge.

## Test plan
Bench parameters: H_PIX=4, V_LINES=3, PULSE_LEN=2, GAP_LEN=3.
1. Reset: with `irst`=1 and `frame_enable`=1, require `frame_done`=1, `pix_ready`=0, `frame_cnt`=0. Release `irst` → `pix_ready`=1 after 1 cycle.
2. Full frame: `pix_valid` held 1. After 12 accepts, `frame_done`=0 for exactly 2 cycles. `frame_cnt`=1. `pix_ready`=0 for 2+3+1=6 cycles, then 1.
3. Stalls: toggle `pix_valid` 1/0 every cycle → 12 accepts over 23–24 cycles. `pix_x`/`pix_y` sequence (0,0)…(3,2). `frame_done` falls only on the 12th accept.
4. Abort: drop `frame_enable` after 5 accepts → `abort`=1 for 1 cycle, `pix_x`=`pix_y`=0, `frame_cnt` unchanged, `frame_done` stays 1. Re-raise → next frame again needs 12 accepts.
5. Ignore in PULSE/GAP: drop `frame_enable` during PULSE → pulse is still exactly 2 cycles and `frame_cnt` still increments. The block then waits in IDLE until `frame_enable`=1.
6. Async reset mid-pulse: assert `irst` during PULSE → `frame_done`=1 with no clock edge needed, and all counters are 0.
